// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: steps through a small {opcode, immediate} program and
// hands each command to the queue-calculator ALU. It waits for the ALU's sync
// pulse before issuing the next command. It also tracks queue occupancy and
// refuses commands that would underflow or overflow the queue.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   load_en/load_addr/load_data program write port (IDLE/DONE/ERR only)
//   start                       run the program from address 0
//   alu_sync, alu_result        ALU completion pulse and its result
//   alu_valid/alu_opcode/push_val  command issued to the ALU
//   busy, done, error           run status (error: 1 underflow, 2 overflow, 3 timeout)
//   last_result, occupancy      last arithmetic result, tracked queue fill
module alu_cmd_sequencer #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned SYNC_TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [10:0]                  load_data,
  input  logic                         start,
  input  logic                         alu_sync,
  input  logic [7:0]                   alu_result,
  output logic                         alu_valid,
  output logic [2:0]                   alu_opcode,
  output logic [7:0]                   push_val,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   error,
  output logic [7:0]                   last_result,
  output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned OCC_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned TMO_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned WORD_W = 11;

  localparam logic [2:0] PUSH_CODE = 3'd0;
  localparam logic [2:0] POP_CODE  = 3'd1;
  localparam logic [2:0] ADD_CODE  = 3'd2;
  localparam logic [2:0] REM_CODE  = 3'd6;
  localparam logic [2:0] HALT_CODE = 3'd7;

  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [2:0]        op_q, op_nxt;
  logic [TMO_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              valid_nxt, busy_nxt, done_nxt;
  logic [2:0]        opcode_nxt;
  logic [7:0]        push_nxt, result_nxt;
  logic [1:0]        error_nxt, op_err;
  logic [OCC_W-1:0]  occ_nxt;
  logic              mem_we;
  logic [WORD_W-1:0] rd_word;

  // Error code a command would raise at the given occupancy (0 = issuable).
  function automatic logic [1:0] cmd_err(input logic [2:0] op, input logic [OCC_W-1:0] occ);
    cmd_err = 2'd0;
    case (op)
      PUSH_CODE: if (occ >= OCC_W'(QUEUE_DEPTH)) cmd_err = ERR_OVER;
      POP_CODE:  if (occ < OCC_W'(1)) cmd_err = ERR_UNDER;
      HALT_CODE: cmd_err = 2'd0;
      default:   if (occ < OCC_W'(2)) cmd_err = ERR_UNDER;
    endcase
  endfunction

  // Program memory: no reset, writable only while the sequencer is parked.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      op_q        <= '0;
      wait_cnt    <= '0;
      alu_valid   <= 1'b0;
      alu_opcode  <= '0;
      push_val    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= '0;
      last_result <= '0;
      occupancy   <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      op_q        <= op_nxt;
      wait_cnt    <= wait_cnt_nxt;
      alu_valid   <= valid_nxt;
      alu_opcode  <= opcode_nxt;
      push_val    <= push_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      last_result <= result_nxt;
      occupancy   <= occ_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    op_nxt       = op_q;
    wait_cnt_nxt = wait_cnt;
    valid_nxt    = 1'b0;
    opcode_nxt   = alu_opcode;
    push_nxt     = '0;
    done_nxt     = done;
    error_nxt    = error;
    result_nxt   = last_result;
    occ_nxt      = occupancy;
    mem_we       = 1'b0;
    rd_word      = mem[pc];
    op_err       = cmd_err(op_q, occupancy);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        mem_we = load_en;
        if (start) begin
          pc_nxt    = '0;
          done_nxt  = 1'b0;
          error_nxt = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // The memory read lands on this edge; the command registers are
        // loaded from it directly so alu_valid is high during ISSUE.
        op_nxt    = rd_word[10:8];
        state_nxt = S_ISSUE;
        if (rd_word[10:8] != HALT_CODE && cmd_err(rd_word[10:8], occupancy) == 2'd0) begin
          valid_nxt  = 1'b1;
          opcode_nxt = rd_word[10:8];
          push_nxt   = (rd_word[10:8] == PUSH_CODE) ? rd_word[7:0] : 8'd0;
        end
      end
      S_ISSUE: begin
        wait_cnt_nxt = '0;
        if (op_q == HALT_CODE) begin
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (op_err != 2'd0) begin
          error_nxt = op_err;
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_WAIT;
          if (op_q == PUSH_CODE) occ_nxt = occupancy + OCC_W'(1);
          else                   occ_nxt = occupancy - OCC_W'(1);
        end
      end
      S_WAIT: begin
        if (alu_sync) begin
          if (op_q >= ADD_CODE && op_q <= REM_CODE) result_nxt = alu_result;
          if (pc == ADDR_W'(DEPTH - 1)) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = S_FETCH;
          end
        end else if (wait_cnt == TMO_W'(SYNC_TIMEOUT - 1)) begin
          error_nxt = ERR_TMO;
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + TMO_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a FIFO queue-calculator ALU model
// that answers two cycles after each command.
module tb_alu_cmd_sequencer;

  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned QUEUE_DEPTH  = 8;
  localparam int unsigned SYNC_TIMEOUT = 15;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MULL = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [10:0]       load_data = '0;
  logic              start = 1'b0;
  wire               alu_sync;
  wire  [7:0]        alu_result;
  logic              alu_valid;
  logic [2:0]        alu_opcode;
  logic [7:0]        push_val;
  logic              busy;
  logic              done;
  logic [1:0]        error;
  logic [7:0]        last_result;
  logic [3:0]        occupancy;

  logic       model_sync = 1'b0;
  logic       tb_sync = 1'b0;
  logic [7:0] model_result = '0;
  bit         model_en = 1'b1;

  assign alu_sync   = model_sync | tb_sync;
  assign alu_result = model_result;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .ADDR_W(ADDR_W), .QUEUE_DEPTH(QUEUE_DEPTH), .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .alu_sync(alu_sync),
    .alu_result(alu_result), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
    .push_val(push_val), .busy(busy), .done(done), .error(error),
    .last_result(last_result), .occupancy(occupancy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: log every command pulse and every change of last_result.
  int         pulses = 0;
  logic [7:0] push_log[$];
  logic [7:0] res_log[$];
  logic [7:0] prev_res = '0;

  always @(negedge clk) begin
    if (alu_valid) begin
      pulses++;
      push_log.push_back(push_val);
    end
    if (last_result !== prev_res) begin
      res_log.push_back(last_result);
      prev_res = last_result;
    end
  end

  // FIFO ALU model; acts 1 time unit after the falling edge so bench drives
  // made on that edge are already settled.
  logic [7:0] mq[$];
  int         cd = 0;
  logic [7:0] pend_res = '0;
  logic [7:0] opa, opb;

  always @(negedge clk) begin
    #1;
    model_sync = 1'b0;
    if (rst) begin
      cd = 0;
      mq.delete();
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && model_en) begin
          model_sync   = 1'b1;
          model_result = pend_res;
        end
      end
      if (alu_valid) begin
        cd = 2;
        if (alu_opcode == OP_PUSH) begin
          mq.push_back(push_val);
          pend_res = push_val;
        end else if (alu_opcode == OP_POP) begin
          pend_res = 8'd0;
          if (mq.size() > 0) pend_res = mq.pop_front();
        end else begin
          opa = 8'd0;
          opb = 8'd0;
          if (mq.size() > 0) opa = mq.pop_front();
          if (mq.size() > 0) opb = mq.pop_front();
          case (alu_opcode)
            OP_ADD:  pend_res = opa + opb;
            OP_MULL: pend_res = opa * opb;
            OP_SUB:  pend_res = opa - opb;
            OP_DIV:  pend_res = (opb == 8'd0) ? 8'd0 : opa / opb;
            OP_REM:  pend_res = (opb == 8'd0) ? 8'd0 : opa % opb;
            default: pend_res = 8'd0;
          endcase
          mq.push_back(pend_res);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input int unsigned a, input logic [2:0] op, input logic [7:0] imm);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = {op, imm};
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic load_nominal();
    load(0, OP_PUSH, 8'd1); load(1, OP_PUSH, 8'd2);
    load(2, OP_PUSH, 8'd3); load(3, OP_PUSH, 8'd4);
    load(4, OP_ADD, 8'd0);  load(5, OP_MULL, 8'd0);
    load(6, OP_POP, 8'd0);  load(7, OP_POP, 8'd0);
    load(8, OP_HALT, 8'd0);
  endtask

  // Returns in the FETCH cycle that follows the start edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error != 2'd0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check(tag, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input logic [2:0] op, input string tag);
    int n = 0;
    while (!(alu_valid && alu_opcode == op) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check(tag, 32'(alu_valid), 32'd1);
  endtask

  logic [7:0] exp_nom [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
  int cb, pb, rb;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", 32'(alu_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_result", 32'(last_result), 0);

    // Nominal program
    do_reset();
    load_nominal();
    cb = pulses; pb = push_log.size(); rb = res_log.size();
    pulse_start();
    check("nom_fetch_valid", 32'(alu_valid), 0);
    check("nom_fetch_busy", 32'(busy), 1);
    @(negedge clk);
    check("nom_issue_valid", 32'(alu_valid), 1);
    check("nom_issue_push", 32'(push_val), 1);
    wait_end("nom_end_timeout");
    check("nom_pulses", 32'(pulses - cb), 8);
    for (int i = 0; i < 8; i++) check($sformatf("nom_push%0d", i), 32'(push_log[pb+i]), 32'(exp_nom[i]));
    check("nom_res_cnt", 32'(res_log.size() - rb), 2);
    check("nom_res0", 32'(res_log[rb]), 3);
    check("nom_res1", 32'(res_log[rb+1]), 12);
    check("nom_occ", 32'(occupancy), 0);
    check("nom_done", 32'(done), 1);
    check("nom_error", 32'(error), 0);
    check("nom_busy", 32'(busy), 0);

    // Underflow: POP on an empty queue
    do_reset();
    load(0, OP_POP, 8'd0); load(1, OP_HALT, 8'd0);
    cb = pulses;
    pulse_start();
    @(negedge clk);
    check("uf_issue_err", 32'(error), 0);
    check("uf_issue_busy", 32'(busy), 1);
    @(negedge clk);
    check("uf_error", 32'(error), 1);
    check("uf_busy", 32'(busy), 0);
    check("uf_pulses", 32'(pulses - cb), 0);
    check("uf_occ", 32'(occupancy), 0);
    check("uf_done", 32'(done), 0);

    // Overflow: ninth PUSH into a depth-8 queue
    do_reset();
    for (int i = 0; i < 9; i++) load(i, OP_PUSH, 8'd5);
    load(9, OP_HALT, 8'd0);
    cb = pulses;
    pulse_start();
    wait_end("of_end_timeout");
    check("of_pulses", 32'(pulses - cb), 8);
    check("of_error", 32'(error), 2);
    check("of_occ", 32'(occupancy), 8);
    check("of_done", 32'(done), 0);

    // Timeout: ALU never answers
    do_reset();
    model_en = 1'b0;
    load(0, OP_PUSH, 8'd7); load(1, OP_HALT, 8'd0);
    pulse_start();
    wait_valid(OP_PUSH, "tmo_valid_timeout");
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) check("tmo_early", 32'(error), 0);
      if (i == 16) check("tmo_error", 32'(error), 3);
    end
    check("tmo_occ", 32'(occupancy), 1);
    check("tmo_busy", 32'(busy), 0);
    model_en = 1'b1;

    // Reset during the WAIT of an ADD, late sync afterwards
    do_reset();
    load(0, OP_PUSH, 8'd9); load(1, OP_PUSH, 8'd8);
    load(2, OP_ADD, 8'd0);  load(3, OP_HALT, 8'd0);
    pulse_start();
    wait_valid(OP_ADD, "rw_valid_timeout");
    @(negedge clk);
    check("rw_pre_occ", 32'(occupancy), 1);
    check("rw_pre_opcode", 32'(alu_opcode), 2);
    rst = 1'b1;
    @(negedge clk);
    check("rw_opcode", 32'(alu_opcode), 0);
    check("rw_valid", 32'(alu_valid), 0);
    check("rw_push", 32'(push_val), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_done", 32'(done), 0);
    check("rw_error", 32'(error), 0);
    check("rw_occ", 32'(occupancy), 0);
    check("rw_result", 32'(last_result), 0);
    rst = 1'b0;
    tb_sync = 1'b1;
    @(negedge clk);
    tb_sync = 1'b0;
    check("rw_sync_busy", 32'(busy), 0);
    check("rw_sync_occ", 32'(occupancy), 0);
    check("rw_sync_result", 32'(last_result), 0);
    cb = pulses; pb = push_log.size();
    pulse_start();
    wait_end("rw_end_timeout");
    check("rw_pulses", 32'(pulses - cb), 3);
    check("rw_first_push", 32'(push_log[pb]), 9);
    check("rw_second_push", 32'(push_log[pb+1]), 8);
    check("rw_last_result", 32'(last_result), 17);
    check("rw_occ_end", 32'(occupancy), 1);
    check("rw_done_end", 32'(done), 1);

    // start/load_en while busy are ignored
    do_reset();
    load_nominal();
    cb = pulses; rb = res_log.size();
    pulse_start();
    wait_valid(OP_PUSH, "ig_valid_timeout");
    @(negedge clk);
    start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = {OP_HALT, 8'd0};
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    wait_end("ig_end_timeout");
    check("ig_pulses", 32'(pulses - cb), 8);
    check("ig_res0", 32'(res_log[rb]), 3);
    check("ig_res1", 32'(res_log[rb+1]), 12);
    check("ig_occ", 32'(occupancy), 0);
    check("ig_done", 32'(done), 1);
    check("ig_error", 32'(error), 0);
    cb = pulses; pb = push_log.size();
    pulse_start();
    wait_end("ig_rerun_timeout");
    check("ig_rerun_pulses", 32'(pulses - cb), 8);
    check("ig_rerun_push0", 32'(push_log[pb]), 1);

    // Program end without HALT: done at the last address
    do_reset();
    for (int i = 0; i < 16; i++) load(i, (i % 2 == 0) ? OP_PUSH : OP_POP, 8'(i + 1));
    cb = pulses;
    pulse_start();
    wait_end("end_timeout");
    check("end_pulses", 32'(pulses - cb), 16);
    check("end_done", 32'(done), 1);
    check("end_error", 32'(error), 0);
    check("end_occ", 32'(occupancy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the queue calculator. Holds a small program of {opcode, immediate} words, steps through it on `start`, and presents each command to the ALU, one at a time, waiting for the ALU's `sync` pulse before issuing the next. It tracks queue occupancy so it can refuse commands that would underflow or overflow the queue. It also captures the last arithmetic result and reports done/error status.

## Interface
- `ADDR_W`, 4: program address width; the program holds 2^ADDR_W words.
- `QUEUE_DEPTH`, 8: queue capacity in entries.
- `SYNC_TIMEOUT`, 15: maximum number of WAIT cycles allowed before a timeout error.
- Opcodes: `PUSH_CODE` 0, `POP_CODE` 1, `ADD_CODE` 2, `MULL_CODE` 3, `SUB_CODE` 4, `DIV_CODE` 5, `REM_CODE` 6, `HALT_CODE` 7.
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  writes one program word this cycle.
- `load_addr`  in  ADDR_W  program write address.
- `load_data`  in  11  program word: [10:8] = opcode, [7:0] = immediate.
- `start`  in  1  begin execution at address 0.
- `alu_sync`  in  1  ALU done pulse, one cycle wide.
- `alu_result`  in  8  ALU result; valid while `alu_sync` = 1.
- `alu_valid`  out  1  command present, high for exactly one cycle per command.
- `alu_opcode`  out  3  opcode of the command.
- `push_val`  out  8  immediate for PUSH; 0 for all other commands.
- `busy`  out  1  high in the FETCH, ISSUE and WAIT states.
- `done`  out  1  HALT reached or program end reached.
- `error`  out  2  error code: 0 none, 1 underflow, 2 overflow, 3 timeout.
- `last_result`  out  8  result of the most recent arithmetic command.
- `occupancy`  out  clog2(QUEUE_DEPTH)+1  queue entry count as tracked by this block.

## Operation
- **Program memory:** 2^ADDR_W × 11 bits, synchronous read, not cleared by reset.
  - Writes happen only when the state is IDLE, DONE or ERR.
  - `load_en` in any other state is ignored.
- **States:** IDLE, FETCH, ISSUE, WAIT, DONE, ERR.
- **IDLE / DONE / ERR:**
  - `start` = 1 sets pc = 0, clears `done` and `error`, and moves to FETCH.
  - `start` in FETCH, ISSUE or WAIT is ignored.
- **FETCH:** reads mem[pc]; next state is ISSUE.
- **ISSUE:** decodes the fetched word.
  - HALT: go to DONE; `alu_valid` stays low.
  - PUSH with occupancy == QUEUE_DEPTH: `error` = 2, go to ERR.
  - POP with occupancy < 1: `error` = 1, go to ERR.
  - ADD..REM with occupancy < 2: `error` = 1, go to ERR.
  - Otherwise: drive `alu_valid` = 1 with `alu_opcode`/`push_val`, update occupancy, and go to WAIT.
    - PUSH: occupancy +1.
    - POP: occupancy −1.
    - ADD..REM: occupancy −1 (two entries popped, one pushed).
- **WAIT:**
  - `alu_sync` = 1: for ADD..REM, latch `alu_result` into `last_result`.
    - If pc == 2^ADDR_W−1, go to DONE (pc never wraps).
    - Otherwise pc +1 and go to FETCH.
  - If the WAIT cycle count reaches SYNC_TIMEOUT without `alu_sync`: `error` = 3, go to ERR.
- **`alu_sync` outside WAIT:** ignored, including a pulse in the ISSUE cycle itself.
- **Occupancy across runs:**
  - Persists across runs, because the queue retains its contents.
  - Cleared only by `rst`.
  - Not changed on the error path.
- **Reset, including mid-operation:** state IDLE, pc 0, and all outputs 0.
  - This covers `alu_valid`, `alu_opcode`, `push_val`, `busy`, `done`, `error`, `last_result` and `occupancy`.
  - A command already issued is abandoned; its late `alu_sync` is ignored.
- **Output hold:** `alu_opcode` holds its last issued value between commands. `push_val` returns to 0 when `alu_valid` is low.

## Timing
- **Start to first command:** `start` sampled at edge N gives FETCH in cycle N+1 and ISSUE (`alu_valid` = 1) in cycle N+2.
- **Minimum issue interval:** 3 cycles per command (FETCH, ISSUE, one WAIT cycle with `alu_sync`).
- **HALT:** `done` = 1 two cycles after the HALT word enters FETCH, and holds until `start` or `rst`.
- **`last_result` / `occupancy` update timing:**
  - `last_result` updates on the edge that samples `alu_sync`.
  - `occupancy` updates on the edge ending ISSUE.
- **Error:** `error` is set on the edge ending ISSUE (codes 1/2) or ending the last WAIT cycle (code 3), and holds until `start` or `rst`.
- **`busy`:** a registered function of state; it falls in the same cycle that `done` or `error` rises.

## Test plan
- **Nominal program:** load PUSH 1, PUSH 2, PUSH 3, PUSH 4, ADD, MULL, POP, POP, HALT; FIFO ALU model returning `alu_sync` 2 cycles after `alu_valid`.
  - Required: 8 `alu_valid` pulses with `push_val` 1, 2, 3, 4, 0, 0, 0, 0.
  - `last_result` 3, then 12.
  - Final occupancy 0, `done` = 1, `error` = 0.
- **Underflow:** from reset, program POP, HALT.
  - Required: `error` = 1, zero `alu_valid` pulses, occupancy 0, `busy` = 0.
- **Overflow:** 9× PUSH 5 with QUEUE_DEPTH = 8.
  - Required: 8 `alu_valid` pulses, `error` = 2 at the 9th command, occupancy 8.
- **Timeout:** PUSH 7 with the ALU model never asserting `alu_sync`.
  - Required: `error` = 3 exactly SYNC_TIMEOUT cycles after WAIT is entered; occupancy 1.
- **Reset mid-WAIT:** assert `rst` during WAIT, then deliver `alu_sync` the next cycle.
  - Required: all outputs 0, state IDLE, the sync is ignored, and `start` reruns the program from address 0.
- **Ignored inputs while busy:** `start` and `load_en` asserted during WAIT.
  - Required: no restart, program memory unchanged, and the run completes as in the nominal program.
